// File: rtl/pong_score_keeper_if.sv
// Signal bundle between the pong game core / start button and the score keeper.
// The master drives the requests; the slave (score keeper) drives the scoreboard outputs.
interface pong_score_keeper_if;
   logic       start;
   logic       point_p1;
   logic       point_p2;
   logic [3:0] score_p1;
   logic [3:0] score_p2;
   logic       serve_p2;
   logic       play_en;
   logic [1:0] winner;
   logic       game_over;

   modport master (
      output start, point_p1, point_p2,
      input  score_p1, score_p2, serve_p2, play_en, winner, game_over
   );

   modport slave (
      input  start, point_p1, point_p2,
      output score_p1, score_p2, serve_p2, play_en, winner, game_over
   );
endinterface

// File: rtl/pong_score_keeper.sv
// Point counter, game-end and serve-side tracker for the ping-pong box.
// Optional feature: define DEUCE_EN to require a 2-point lead with tie collapse at deuce.
module pong_score_keeper #(
   parameter int WIN_SCORE   = 11,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int SERVE_SWAP  = 2
) (
   input logic                 clk,
   input logic                 rst,
   pong_score_keeper_if.slave  bus
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SW = $clog2(SERVE_SWAP + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] SWAP_V    = SW'(SERVE_SWAP);
   localparam logic [3:0]    WIN4      = 4'(WIN_SCORE);
`ifdef DEUCE_EN
   localparam logic [3:0]    WINM1     = 4'(WIN_SCORE - 1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_OVER} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_start_q, r_p1_q, r_p2_q;
   logic [3:0]    r_score_p1, r_score_p2, w_s1_nxt, w_s2_nxt;
   logic          r_serve_p2, w_serve_nxt;
   logic [1:0]    r_winner, w_winner_nxt;
   logic          r_play_en, r_game_over;
   logic [HW-1:0] r_hold_cnt, w_hold_nxt;
   logic [SW-1:0] r_serve_cnt, w_scnt_nxt;

   logic          w_start_rise, w_p1_rise, w_p2_rise;
   logic          w_pt_p1, w_pt_p2;
   logic [3:0]    w_n1, w_n2;
   logic          w_win1, w_win2, w_tie, w_deuce_srv;
   logic [SW-1:0] w_scnt_inc;

   assign w_start_rise = bus.start    & ~r_start_q;
   assign w_p1_rise    = bus.point_p1 & ~r_p1_q;
   assign w_p2_rise    = bus.point_p2 & ~r_p2_q;

   // A simultaneous rise from both players is an ambiguous rally and awards nothing.
   assign w_pt_p1 = w_p1_rise & ~w_p2_rise;
   assign w_pt_p2 = w_p2_rise & ~w_p1_rise;

   assign w_n1       = r_score_p1 + {3'b000, w_pt_p1};
   assign w_n2       = r_score_p2 + {3'b000, w_pt_p2};
   assign w_scnt_inc = r_serve_cnt + SW'(1);

`ifdef DEUCE_EN
   assign w_win1      = w_pt_p1 && (w_n1 >= WIN4) && ({1'b0, w_n1} >= ({1'b0, w_n2} + 5'd2));
   assign w_win2      = w_pt_p2 && (w_n2 >= WIN4) && ({1'b0, w_n2} >= ({1'b0, w_n1} + 5'd2));
   assign w_tie       = (w_n1 == w_n2) && (w_n1 >= WIN4);
   assign w_deuce_srv = (w_n1 >= WINM1) && (w_n2 >= WINM1);
`else
   assign w_win1      = w_pt_p1 && (w_n1 >= WIN4);
   assign w_win2      = w_pt_p2 && (w_n2 >= WIN4);
   assign w_tie       = 1'b0;
   assign w_deuce_srv = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_s1_nxt     = r_score_p1;
      w_s2_nxt     = r_score_p2;
      w_serve_nxt  = r_serve_p2;
      w_winner_nxt = r_winner;
      w_hold_nxt   = r_hold_cnt;
      w_scnt_nxt   = r_serve_cnt;

      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_start_rise) begin
               w_state_nxt  = S_PLAY;
               w_s1_nxt     = '0;
               w_s2_nxt     = '0;
               w_winner_nxt = 2'b00;
               w_serve_nxt  = 1'b0;
               w_scnt_nxt   = '0;
            end
         end
         S_PLAY: begin
            if (w_pt_p1 || w_pt_p2) begin
               // Tie at or above the win score folds back so scores stay in 4 bits.
               if (w_tie) begin
                  w_s1_nxt = WIN4 - 4'd1;
                  w_s2_nxt = WIN4 - 4'd1;
               end else begin
                  w_s1_nxt = w_n1;
                  w_s2_nxt = w_n2;
               end

               if (w_deuce_srv) begin
                  w_serve_nxt = ~r_serve_p2;
                  w_scnt_nxt  = '0;
               end else if (w_scnt_inc == SWAP_V) begin
                  w_serve_nxt = ~r_serve_p2;
                  w_scnt_nxt  = '0;
               end else begin
                  w_scnt_nxt  = w_scnt_inc;
               end

               if (w_win1 || w_win2) begin
                  w_state_nxt  = S_OVER;
                  w_winner_nxt = w_win1 ? 2'b01 : 2'b10;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_hold_nxt  = '0;
               end
            end
         end
         S_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = S_PLAY;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + HW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_start_q   <= 1'b1;
         r_p1_q      <= 1'b1;
         r_p2_q      <= 1'b1;
         r_score_p1  <= '0;
         r_score_p2  <= '0;
         r_serve_p2  <= 1'b0;
         r_winner    <= 2'b00;
         r_play_en   <= 1'b0;
         r_game_over <= 1'b0;
         r_hold_cnt  <= '0;
         r_serve_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_start_q   <= bus.start;
         r_p1_q      <= bus.point_p1;
         r_p2_q      <= bus.point_p2;
         r_score_p1  <= w_s1_nxt;
         r_score_p2  <= w_s2_nxt;
         r_serve_p2  <= w_serve_nxt;
         r_winner    <= w_winner_nxt;
         r_play_en   <= (w_state_nxt == S_PLAY);
         r_game_over <= (w_state_nxt == S_OVER);
         r_hold_cnt  <= w_hold_nxt;
         r_serve_cnt <= w_scnt_nxt;
      end
   end

   assign bus.score_p1  = r_score_p1;
   assign bus.score_p2  = r_score_p2;
   assign bus.serve_p2  = r_serve_p2;
   assign bus.winner    = r_winner;
   assign bus.play_en   = r_play_en;
   assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed scenarios plus random play against a rule-level model.
module tb_pong_score_keeper;
   localparam int HOLD = 4;
   localparam int WIN  = 11;
   localparam int SWAP = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pong_score_keeper_if bus ();

   pong_score_keeper #(
      .WIN_SCORE   (WIN),
      .HOLD_CYCLES (HOLD),
      .SERVE_SWAP  (SWAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: game rules in plain integers, no notion of the RTL state machine.
   int m_s1, m_s2, m_winner, m_hold_left, m_since_swap;
   bit m_serve, m_play, m_over;
   bit q_st, q_p1, q_p2;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_winner = 0; m_hold_left = 0; m_since_swap = 0;
      m_serve = 0; m_play = 0; m_over = 0;
      q_st = 1; q_p1 = 1; q_p2 = 1;
   endtask

   task automatic award(input bit to_p1);
      bit won;
      bit deuce_zone;
      if (to_p1) m_s1++; else m_s2++;
`ifdef DEUCE_EN
      deuce_zone = (m_s1 >= WIN - 1) && (m_s2 >= WIN - 1);
      won = to_p1 ? (m_s1 >= WIN && m_s1 - m_s2 >= 2) : (m_s2 >= WIN && m_s2 - m_s1 >= 2);
      if (m_s1 == m_s2 && m_s1 >= WIN) begin m_s1 = WIN - 1; m_s2 = WIN - 1; end
`else
      deuce_zone = 0;
      won = to_p1 ? (m_s1 >= WIN) : (m_s2 >= WIN);
`endif
      if (deuce_zone) begin
         m_serve = !m_serve; m_since_swap = 0;
      end else begin
         m_since_swap++;
         if (m_since_swap == SWAP) begin m_since_swap = 0; m_serve = !m_serve; end
      end
      m_play = 0;
      if (won) begin m_over = 1; m_winner = to_p1 ? 1 : 2; end
      else m_hold_left = HOLD;
   endtask

   task automatic model_step();
      bit rs, r1, r2;
      if (rst) begin model_reset(); return; end
      rs = bus.start & !q_st; r1 = bus.point_p1 & !q_p1; r2 = bus.point_p2 & !q_p2;
      q_st = bus.start; q_p1 = bus.point_p1; q_p2 = bus.point_p2;
      if (m_hold_left > 0) begin
         m_hold_left--;
         if (m_hold_left == 0) m_play = 1;
      end else if (!m_play) begin
         if (rs) begin
            m_s1 = 0; m_s2 = 0; m_winner = 0; m_serve = 0; m_since_swap = 0;
            m_play = 1; m_over = 0;
         end
      end else if (r1 != r2) begin
         award(r1);
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("score_p1",  int'(bus.score_p1),  m_s1);
      chk("score_p2",  int'(bus.score_p2),  m_s2);
      chk("serve_p2",  int'(bus.serve_p2),  int'(m_serve));
      chk("winner",    int'(bus.winner),    m_winner);
      chk("play_en",   int'(bus.play_en),   int'(m_play));
      chk("game_over", int'(bus.game_over), int'(m_over));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic point(input bit to_p1);
      @(negedge clk);
      if (to_p1) bus.point_p1 = 1'b1; else bus.point_p2 = 1'b1;
      @(negedge clk);
      bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;
      tick(HOLD + 2);
   endtask

   task automatic press_start();
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0; bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;

      // 1: reset values
      tick(3);
      chk("rst_score_p1", int'(bus.score_p1), 0);
      chk("rst_score_p2", int'(bus.score_p2), 0);
      chk("rst_winner",   int'(bus.winner),   0);
      chk("rst_play_en",  int'(bus.play_en),  0);
      chk("rst_over",     int'(bus.game_over), 0);
      chk("rst_serve",    int'(bus.serve_p2), 0);
      rst = 1'b0;
      tick(2);
      point(1'b1);
      chk("idle_ignores_point", int'(bus.score_p1), 0);

      // 2: basic scoring and serve swap
      press_start();
      chk("start_play_en", int'(bus.play_en), 1);
      point(1'b1); point(1'b1);
      chk("serve_after_2", int'(bus.serve_p2), 1);
      point(1'b1); point(1'b0);
      chk("score_3_1_p1", int'(bus.score_p1), 3);
      chk("score_3_1_p2", int'(bus.score_p2), 1);
      chk("serve_after_4", int'(bus.serve_p2), 0);

      // 3: win at 11/5, frozen in OVER, restart
      for (int i = 0; i < 7; i++) point(1'b1);
      for (int i = 0; i < 4; i++) point(1'b0);
      chk("score_10_p1", int'(bus.score_p1), 10);
      chk("score_5_p2",  int'(bus.score_p2), 5);
      point(1'b1);
      chk("win_score_p1", int'(bus.score_p1), 11);
      chk("win_winner",   int'(bus.winner),   1);
      chk("win_over",     int'(bus.game_over), 1);
      point(1'b1); point(1'b0);
      chk("over_frozen_p1", int'(bus.score_p1), 11);
      chk("over_frozen_p2", int'(bus.score_p2), 5);
      press_start();
      chk("restart_p1",     int'(bus.score_p1), 0);
      chk("restart_play",   int'(bus.play_en),  1);
      chk("restart_winner", int'(bus.winner),   0);

      // 4: simultaneous rise, rise during hold, input held through reset
      @(negedge clk); bus.point_p1 = 1'b1; bus.point_p2 = 1'b1;
      @(negedge clk); bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;
      tick(2);
      chk("both_p1", int'(bus.score_p1), 0);
      chk("both_p2", int'(bus.score_p2), 0);
      @(negedge clk); bus.point_p1 = 1'b1;
      @(negedge clk); bus.point_p1 = 1'b0; bus.point_p2 = 1'b1;
      chk("hold_play_en", int'(bus.play_en), 0);
      @(negedge clk); bus.point_p2 = 1'b0;
      tick(HOLD + 2);
      chk("hold_p1", int'(bus.score_p1), 1);
      chk("hold_p2", int'(bus.score_p2), 0);
      @(negedge clk); bus.point_p1 = 1'b1; rst = 1'b1;
      tick(2); rst = 1'b0;
      tick(2);
      press_start();
      tick(3);
      chk("held_p1_no_point", int'(bus.score_p1), 0);
      chk("held_play_en",     int'(bus.play_en),  1);
      bus.point_p1 = 1'b0;
      tick(2);

`ifdef DEUCE_EN
      // 5: deuce handling
      for (int i = 0; i < 10; i++) begin point(1'b1); point(1'b0); end
      point(1'b1);
      chk("deuce_11_10_p1", int'(bus.score_p1), 11);
      chk("deuce_no_win",   int'(bus.winner),   0);
      point(1'b0);
      chk("deuce_collapse_p1", int'(bus.score_p1), 10);
      chk("deuce_collapse_p2", int'(bus.score_p2), 10);
      point(1'b1); point(1'b1);
      chk("deuce_win_p1",  int'(bus.score_p1), 12);
      chk("deuce_win_p2",  int'(bus.score_p2), 10);
      chk("deuce_winner",  int'(bus.winner),   1);
      press_start();
`endif

      // 6: asynchronous reset in the middle of a hold at 7/6
      for (int i = 0; i < 6; i++) begin point(1'b1); point(1'b0); end
      @(negedge clk); bus.point_p1 = 1'b1;
      @(negedge clk); bus.point_p1 = 1'b0;
      chk("pre_rst_p1", int'(bus.score_p1), 7);
      chk("pre_rst_p2", int'(bus.score_p2), 6);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_p1",   int'(bus.score_p1), 0);
      chk("async_rst_p2",   int'(bus.score_p2), 0);
      chk("async_rst_play", int'(bus.play_en),  0);
      chk("async_rst_over", int'(bus.game_over), 0);
      @(negedge clk); rst = 1'b0;
      tick(2);

      // Random play
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         bus.start    = ($urandom_range(0, 29) == 0);
         bus.point_p1 = ($urandom_range(0, 3) == 0);
         bus.point_p2 = ($urandom_range(0, 3) == 0);
         rst          = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0; bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
